// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: port identities, address
// classification bit and the read-response record.
package dmem_arb_pkg;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  localparam int unsigned MMIO_BIT = 31;

  typedef struct packed {
    logic        valid;
    port_e       port;
    logic [31:0] addr;
  } rsp_t;

endpackage

// File: rtl/dmem_arb_rsp.sv
// Response stage: remembers the read granted last cycle, steers DMEM read
// data to that port and holds the read-mux selection address.
module dmem_arb_rsp
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_gnt,
  input  port_e       rd_port,
  input  logic [31:0] rd_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_fetch_addr,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata
);

  rsp_t rsp;

  // Address and port keep their last read value; only valid tracks every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp <= '0;
    end else begin
      rsp.valid <= rd_gnt;
      if (rd_gnt) begin
        rsp.port <= rd_port;
        rsp.addr <= rd_addr;
      end
    end
  end

  always_comb begin
    mem_fetch_addr = rsp.addr;
    p0_rvalid      = rsp.valid && (rsp.port == PORT_CPU);
    p1_rvalid      = rsp.valid && (rsp.port == PORT_DBG);
    p0_rdata       = p0_rvalid ? mem_rdata : '0;
    p1_rdata       = p1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU port has priority, the debug/loader port
// is protected by a starvation limit and may lock the grant for bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  input  logic        p1_lock,
  output logic        mem_we,
  output logic [31:0] mem_ask_addr,
  output logic [31:0] mem_fetch_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             lock_owner;
  logic             rd_gnt;
  port_e            rd_port;

  // Grant outputs are gated by rst so every output reads 0 during reset.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (p1_req && (lock_owner || (starve_cnt == LIMIT))) p1_gnt = 1'b1;
      else if (p0_req)                                      p0_gnt = 1'b1;
      else if (p1_req)                                      p1_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_we       = 1'b0;
    mem_ask_addr = '0;
    mem_wdata    = '0;
    if (!rst) begin
      mem_ask_addr = p1_gnt ? p1_addr  : p0_addr;
      mem_wdata    = p1_gnt ? p1_wdata : p0_wdata;
      mem_we       = (p0_gnt && p0_we) || (p1_gnt && p1_we);
    end
    rd_gnt  = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
    rd_port = p1_gnt ? PORT_DBG : PORT_CPU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      lock_owner <= 1'b0;
    end else begin
      if (p1_req && !p1_gnt)
        starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + CNT_W'(1);
      else
        starve_cnt <= '0;

      if (p1_gnt && p1_lock)       lock_owner <= 1'b1;
      else if (!p1_lock || !p1_req) lock_owner <= 1'b0;
    end
  end

  dmem_arb_rsp u_rsp (
    .clk            (clk),
    .rst            (rst),
    .rd_gnt         (rd_gnt),
    .rd_port        (rd_port),
    .rd_addr        (mem_ask_addr),
    .mem_rdata      (mem_rdata),
    .mem_fetch_addr (mem_fetch_addr),
    .p0_rvalid      (p0_rvalid),
    .p0_rdata       (p0_rdata),
    .p1_rvalid      (p1_rvalid),
    .p1_rdata       (p1_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural DMEM plus a rule-level arbitration and
// memory reference model; directed scenarios followed by random traffic.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_ask_addr, mem_fetch_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_lock(p1_lock),
    .mem_we(mem_we), .mem_ask_addr(mem_ask_addr), .mem_fetch_addr(mem_fetch_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural DMEM: registered BRAM read, MMIO registers read through fetch_addr.
  logic [31:0] bram [256];
  logic [31:0] mmio [4];
  logic [31:0] bram_q;
  logic        pre_clr, pre_en, pre_mmio;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_clr) begin
      for (int i = 0; i < 256; i++) bram[i] <= '0;
      for (int i = 0; i < 4; i++) mmio[i] <= '0;
    end else if (pre_en) begin
      if (pre_mmio) mmio[pre_idx[1:0]] <= pre_val;
      else          bram[pre_idx]      <= pre_val;
    end else if (mem_we) begin
      if (mem_ask_addr[MMIO_BIT]) mmio[mem_ask_addr[3:2]] <= mem_wdata;
      else                        bram[mem_ask_addr[9:2]] <= mem_wdata;
    end
    bram_q <= bram[mem_ask_addr[9:2]];
  end

  assign mem_rdata = mem_fetch_addr[MMIO_BIT] ? mmio[mem_fetch_addr[3:2]] : bram_q;

  // Reference model: arbitration rules, denial history, expected response.
  logic [31:0] ref_bram [256];
  logic [31:0] ref_mmio [4];
  int unsigned m_denied;
  bit          m_lock, m_rv, m_rp;
  logic [31:0] m_rd, m_ra;
  int          last_w;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return a[MMIO_BIT] ? ref_mmio[a[3:2]] : ref_bram[a[9:2]];
  endfunction

  // 0: no grant, 1: port 0, 2: port 1
  function automatic int win_now();
    if (p1_req && m_lock)            return 2;
    if (p1_req && m_denied >= LIM)   return 2;
    if (p0_req)                      return 1;
    if (p1_req)                      return 2;
    return 0;
  endfunction

  task automatic model_edge(input int w);
    logic        we;
    logic [31:0] a, d;
    we = (w == 2) ? p1_we : p0_we;
    a  = (w == 2) ? p1_addr : p0_addr;
    d  = (w == 2) ? p1_wdata : p0_wdata;
    m_rv = (w != 0) && !we;
    m_rp = (w == 2);
    m_rd = m_rv ? ref_read(a) : 32'h0;
    if (m_rv) m_ra = a;
    if (w != 0 && we) begin
      if (a[MMIO_BIT]) ref_mmio[a[3:2]] = d;
      else             ref_bram[a[9:2]] = d;
    end
    m_denied = (p1_req && w != 2) ? m_denied + 1 : 0;
    if (w == 2 && p1_lock)        m_lock = 1'b1;
    else if (!p1_lock || !p1_req) m_lock = 1'b0;
  endtask

  task automatic tick();
    int w;
    w = win_now();
    @(posedge clk);
    model_edge(w);
    last_w = w;
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_denied = 0; m_lock = 0; m_rv = 0; m_rp = 0; m_rd = '0; m_ra = '0;
  endtask

  task automatic preload(input bit is_mmio, input int unsigned idx, input logic [31:0] val);
    pre_en = 1; pre_mmio = is_mmio; pre_idx = idx[7:0]; pre_val = val;
    if (is_mmio) ref_mmio[idx[1:0]] = val;
    else         ref_bram[idx[7:0]] = val;
    @(posedge clk); #1;
    pre_en = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return {1'b1, 27'b0, r[1:0], 2'b00};
    return {22'b0, 4'b0, r[5:2], 2'b00};
  endfunction

  task automatic test_reset();
    logic [164:0] outs;
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 32'h0000_0010;
    p1_req = 1; p1_we = 1; p1_addr = 32'h0000_0020; p1_wdata = 32'h1;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin
      errors++; $display("FAIL reset_pre_gnt: p0_gnt=%b want 1", p0_gnt);
    end
    #1 rst = 1'b1;
    #1;
    outs = {p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
            mem_we, mem_ask_addr, mem_fetch_addr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: outputs=%h want 0", outs);
    end
    @(posedge clk); #1;
    checks++;
    if (p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_drop_rvalid: p0_rvalid=%b want 0", p0_rvalid);
    end
    idle_inputs();
    rst = 1'b0;
    m_denied = 0; m_lock = 0; m_rv = 0; m_rp = 0; m_rd = '0; m_ra = '0;
    @(negedge clk);
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_after_release: rvalid=%b want 00", {p0_rvalid, p1_rvalid});
    end
    tick();
  endtask

  task automatic test_bram_read();
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({p1_gnt, p0_gnt, mem_we, mem_ask_addr} !== {1'b0, 1'b1, 1'b0, 32'h0000_0010}) begin
      errors++; $display("FAIL bram_grant: gnt=%b we=%b addr=%h want 01 0 00000010",
                         {p1_gnt, p0_gnt}, mem_we, mem_ask_addr);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({p0_rvalid, p0_rdata, p1_rvalid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL bram_resp: p0_rvalid=%b p0_rdata=%h p1_rvalid=%b want 1 deadbeef 0",
                         p0_rvalid, p0_rdata, p1_rvalid);
    end
    tick();
  endtask

  task automatic test_mmio();
    do_reset();
    p1_req = 1; p1_we = 0; p1_addr = 32'h8000_0000;
    @(negedge clk);
    checks++;
    if ({p1_gnt, p0_gnt} !== 2'b10) begin
      errors++; $display("FAIL mmio_rd_gnt: gnt=%b want 10", {p1_gnt, p0_gnt});
    end
    tick();
    idle_inputs();
    p0_req = 1; p0_we = 1; p0_addr = 32'h8000_0004; p0_wdata = 32'h0000_00AB;
    @(negedge clk);
    checks++;
    if ({p1_rvalid, p1_rdata, p0_rvalid, mem_fetch_addr} !== {1'b1, 32'h0000_1234, 1'b0, 32'h8000_0000}) begin
      errors++; $display("FAIL mmio_rd_resp: p1_rvalid=%b p1_rdata=%h p0_rvalid=%b fetch=%h want 1 00001234 0 80000000",
                         p1_rvalid, p1_rdata, p0_rvalid, mem_fetch_addr);
    end
    checks++;
    if ({p0_gnt, mem_we, mem_ask_addr, mem_wdata} !== {1'b1, 1'b1, 32'h8000_0004, 32'h0000_00AB}) begin
      errors++; $display("FAIL mmio_wr_drive: gnt=%b we=%b addr=%h wdata=%h want 1 1 80000004 000000ab",
                         p0_gnt, mem_we, mem_ask_addr, mem_wdata);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({p0_rvalid, p1_rvalid, mmio[1]} !== {2'b00, 32'h0000_00AB}) begin
      errors++; $display("FAIL mmio_wr_done: rvalid=%b result=%h want 00 000000ab",
                         {p0_rvalid, p1_rvalid}, mmio[1]);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g;
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = rand_addr();
    p1_req = 1; p1_we = 0; p1_addr = rand_addr();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      exp_g = ((i % 5) == 4) ? 2'b10 : 2'b01;
      checks++;
      if ({p1_gnt, p0_gnt} !== exp_g) begin
        errors++; $display("FAIL starve_gnt[%0d]: gnt=%b want %b", i, {p1_gnt, p0_gnt}, exp_g);
      end
      if (i > 0) begin
        checks++;
        if ({p0_rvalid, p0_rdata, p1_rvalid, p1_rdata} !==
            {m_rv && !m_rp, (m_rv && !m_rp) ? m_rd : 32'h0, m_rv && m_rp, (m_rv && m_rp) ? m_rd : 32'h0}) begin
          errors++; $display("FAIL starve_route[%0d]: p0 %b/%h p1 %b/%h want port%0d data %h",
                             i, p0_rvalid, p0_rdata, p1_rvalid, p1_rdata, m_rp, m_rd);
        end
      end
      tick();
      if (last_w == 1) p0_addr = rand_addr();
      if (last_w == 2) p1_addr = rand_addr();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock();
    int          k;
    logic [1:0]  exp_g;
    do_reset();
    k = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h0000_0020;
    p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 32'h0000_0100; p1_wdata = 32'hA000_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_g = (i >= 4 && i <= 6) ? 2'b10 : 2'b01;
      checks++;
      if ({p1_gnt, p0_gnt} !== exp_g) begin
        errors++; $display("FAIL lock_gnt[%0d]: gnt=%b want %b", i, {p1_gnt, p0_gnt}, exp_g);
      end
      tick();
      if (last_w == 2) begin
        k++;
        p1_addr  = 32'h0000_0100 + 32'(k * 4);
        p1_wdata = 32'hA000_0000 + 32'(k);
        if (k == 3) begin p1_req = 0; p1_lock = 0; end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({p1_gnt, p0_gnt} !== 2'b01) begin
      errors++; $display("FAIL b2b_gnt_a: gnt=%b want 01", {p1_gnt, p0_gnt});
    end
    tick();
    idle_inputs();
    p1_req = 1; p1_we = 0; p1_addr = 32'h8000_0000;
    @(negedge clk);
    checks++;
    if ({p1_gnt, p0_rvalid, p0_rdata, p1_rvalid, mem_fetch_addr} !==
        {1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0010}) begin
      errors++; $display("FAIL b2b_resp_a: p1_gnt=%b p0 %b/%h p1_rvalid=%b fetch=%h want 1 1/deadbeef 0 00000010",
                         p1_gnt, p0_rvalid, p0_rdata, p1_rvalid, mem_fetch_addr);
    end
    tick();
    idle_inputs();
    p0_req = 1; p0_we = 1; p0_addr = 32'h0000_0040; p0_wdata = 32'h0000_0055;
    @(negedge clk);
    checks++;
    if ({p0_gnt, mem_we, p1_rvalid, p1_rdata, p0_rvalid, mem_fetch_addr} !==
        {1'b1, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 32'h8000_0000}) begin
      errors++; $display("FAIL b2b_resp_b: p0_gnt=%b we=%b p1 %b/%h p0_rvalid=%b fetch=%h want 1 1 1/00001234 0 80000000",
                         p0_gnt, mem_we, p1_rvalid, p1_rdata, p0_rvalid, mem_fetch_addr);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({p0_rvalid, p1_rvalid, bram[16]} !== {2'b00, 32'h0000_0055}) begin
      errors++; $display("FAIL b2b_write: rvalid=%b bram[0x40]=%h want 00 00000055",
                         {p0_rvalid, p1_rvalid}, bram[16]);
    end
    tick();
  endtask

  task automatic test_random();
    bit          pend0, pend1;
    int          w;
    logic [1:0]  exp_g;
    do_reset();
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(0, 3) != 0) begin
        pend0 = 1; p0_we = ($urandom_range(0, 2) == 0); p0_addr = rand_addr(); p0_wdata = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1; p1_we = ($urandom_range(0, 2) == 0); p1_addr = rand_addr(); p1_wdata = $urandom;
        p1_lock = ($urandom_range(0, 3) == 0);
      end
      p0_req = pend0;
      p1_req = pend1;
      if (!pend1) p1_lock = 0;
      @(negedge clk);
      w = win_now();
      exp_g = (w == 2) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
      checks++;
      if ({p1_gnt, p0_gnt} !== exp_g) begin
        errors++; $display("FAIL rand_gnt[%0d]: gnt=%b want %b", i, {p1_gnt, p0_gnt}, exp_g);
      end
      if (w != 0) begin
        checks++;
        if ({mem_we, mem_ask_addr, mem_wdata} !==
            ((w == 2) ? {p1_we, p1_addr, p1_wdata} : {p0_we, p0_addr, p0_wdata})) begin
          errors++; $display("FAIL rand_drive[%0d]: we=%b addr=%h wdata=%h port%0d", i,
                             mem_we, mem_ask_addr, mem_wdata, w - 1);
        end
      end else begin
        checks++;
        if (mem_we !== 1'b0) begin
          errors++; $display("FAIL rand_idle_we[%0d]: mem_we=%b want 0", i, mem_we);
        end
      end
      checks++;
      if ({p0_rvalid, p0_rdata, p1_rvalid, p1_rdata} !==
          {m_rv && !m_rp, (m_rv && !m_rp) ? m_rd : 32'h0, m_rv && m_rp, (m_rv && m_rp) ? m_rd : 32'h0}) begin
        errors++; $display("FAIL rand_resp[%0d]: p0 %b/%h p1 %b/%h want valid=%b port%0d data %h",
                           i, p0_rvalid, p0_rdata, p1_rvalid, p1_rdata, m_rv, m_rp, m_rd);
      end
      if (m_rv) begin
        checks++;
        if (mem_fetch_addr !== m_ra) begin
          errors++; $display("FAIL rand_fetch[%0d]: fetch=%h want %h", i, mem_fetch_addr, m_ra);
        end
      end
      tick();
      if (last_w == 1) pend0 = 0;
      if (last_w == 2) pend1 = 0;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    pre_en = 0; pre_mmio = 0; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < 256; i++) ref_bram[i] = '0;
    for (int i = 0; i < 4; i++) ref_mmio[i] = '0;
    rst = 1'b1;
    pre_clr = 1'b1;
    @(posedge clk); #1;
    pre_clr = 1'b0;
    preload(1'b0, 4, 32'hDEAD_BEEF);
    preload(1'b1, 0, 32'h0000_1234);
    test_reset();
    test_bram_read();
    test_mmio();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (BRAM plus the addr[31] MMIO window) between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/loader master.
- Grants at most one access per cycle and returns read data with a uniform 1-cycle latency for both BRAM and MMIO addresses.
- Port 0 has priority. A starvation counter and a port-1 lock bound the wait seen by port 1.
- Sits between the pipeline MEM stage / loader and DMEM.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles port 1 may be requesting-and-denied before it is forced a grant (must be >=1).
- CNT_W, 3: width of the starvation counter (must hold STARVE_LIMIT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write enable (0 = read).
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  32  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: as port 0, for port 1.
- p1_lock  in  1  while high and p1 is granted, p1 keeps the grant on following cycles.
- mem_we  out  1  to DMEM we.
- mem_ask_addr  out  32  to DMEM ask_addr (BRAM addr/write addr).
- mem_fetch_addr  out  32  to DMEM fetch_addr (selects MMIO vs BRAM on the read-mux).
- mem_wdata  out  32  to DMEM wdata.
- mem_rdata  in  32  from DMEM rdata.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0.
  - Internal state is cleared: resp_valid=0, resp_port=0, resp_addr=0, starve_cnt=0, lock_owner=0.
  - Any in-flight read response is dropped.
- Grant decision is combinational and evaluated in the same cycle as req. The first matching rule applies:
  1. lock_owner=1 and p1_req=1 -> grant p1.
  2. starve_cnt==STARVE_LIMIT and p1_req=1 -> grant p1.
  3. p0_req=1 -> grant p0.
  4. p1_req=1 -> grant p1.
  5. Otherwise no grant.
- gnt is asserted only for the winning port. It is never asserted without the matching req. A requester holds req/we/addr/wdata stable until it sees gnt.
- Memory drive in the grant cycle:
  - mem_ask_addr = winner addr.
  - mem_wdata = winner wdata.
  - mem_we = winner we.
  - With no grant: mem_we=0, and mem_ask_addr/mem_wdata = p0 values (don't-care).
- Read pipeline:
  - A granted read sets resp_valid=1, resp_port=winner, resp_addr=addr on the next edge.
  - A granted write or no grant sets resp_valid=0.
  - mem_fetch_addr = resp_addr at all times, which keeps the MMIO read-mux selection aligned with the BRAM 1-cycle latency.
  - Response cycle: p{resp_port}_rvalid=1 and p{resp_port}_rdata=mem_rdata. The other port's rvalid=0, and each port's rdata is 0 when its rvalid=0.
  - Latency is exactly 1 cycle from gnt to rvalid, for both BRAM and MMIO.
  - Back-to-back reads (either port mix) sustain 1 per cycle.
- Writes complete at the grant edge. No response is returned for a write.
- Starvation counter, updated per edge:
  - If p1_req=1 and p1 not granted: starve_cnt += 1, saturating at STARVE_LIMIT.
  - If p1 granted or p1_req=0: starve_cnt = 0.
- Lock:
  - lock_owner is set on an edge where p1 is granted with p1_lock=1.
  - It is cleared on any edge where p1_lock=0 or p1_req=0.
  - While lock_owner=1, p0 sees no grant even if requesting, and starve_cnt stays 0.
- Simultaneous cases:
  - p0 and p1 request in the same cycle with starve_cnt<STARVE_LIMIT and no lock: p0 wins.
  - A read response for one port can coincide with a grant to the other port.
- Reset asserted mid-transaction: a pending rvalid is never issued. Requesters must re-issue the access after reset.

Decomposition:
- Shared package dmem_arb_pkg holds: port-index constants PORT_CPU=0 and PORT_DBG=1, and localparam MMIO_BIT=31 (for the benches' address classification).
- One natural sub-module, dmem_arb_rsp: the response register stage (resp_valid/resp_port/resp_addr, rvalid/rdata demux, mem_fetch_addr drive).
- Grant logic, starvation counter and lock stay in the top.

Test Plan:
- Reset mid-read: p0 read of 0x0000_0010 is granted, rst is pulsed before the next edge -> p0_rvalid never asserts; all outputs are 0 during reset.
- Single read, BRAM: BRAM word 0x0000_0010 preloaded with 0xDEADBEEF; p0 reads 0x0000_0010 -> p0_gnt in cycle N, p0_rvalid=1 with p0_rdata=0xDEADBEEF in cycle N+1, p1_rvalid=0.
- MMIO path: DMEM opr=0x1234. p1 reads 0x8000_0000 -> p1_rdata=0x0000_1234 one cycle after gnt. p0 writes 0x8000_0004 with wdata 0x0000_00AB -> DMEM result=0x00AB next cycle, no rvalid.
- Contention and starvation: p0 and p1 request continuously, STARVE_LIMIT=4 -> p0 granted 4 cycles, p1 granted on the 5th, pattern repeats; every read response is routed to the correct port.
- Lock: p1 issues 3 consecutive writes with p1_lock=1 while p0_req=1 -> p0_gnt=0 for all 3 cycles; p0 is granted the cycle after p1_lock drops.
- Back-to-back mixed traffic: p0 read A, then p1 read B, then p0 write C on consecutive cycles -> rvalid p0 (A data) then p1 (B data) on consecutive cycles; the write produces no response; mem_fetch_addr tracks A then B.
